// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus-side controller.
// Optional build macro used by this slice: SPART_DIV_READBACK_EN.
package spart_pkg;

  // Register map seen from the processor bus
  typedef enum logic [1:0] {
    ADDR_DATA   = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DBL    = 2'b10,
    ADDR_DBH    = 2'b11
  } addr_t;

  // Divisor load sequencing: the low byte is staged until the high byte commits
  typedef enum logic {
    RUN     = 1'b0,
    LO_PEND = 1'b1
  } div_state_t;

  // Bit positions inside the status byte
  localparam int unsigned STAT_RDA     = 0;
  localparam int unsigned STAT_TBR     = 1;
  localparam int unsigned STAT_LO_PEND = 2;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud divisor register and 16x-baud tick generator.
// A down-counter reloads with (effective divisor - 1) each time it reaches
// zero, so ticks are exactly eff_div cycles apart. A commit loads a new
// divisor, restarts the count and suppresses any tick on that cycle.
// With SPART_DIV_READBACK_EN defined the committed divisor is exported
// so the bus side can read it back.
module spart_baud_gen #(
  parameter int unsigned      DIV_W     = 16,
  parameter logic [DIV_W-1:0] RESET_DIV = 16'd326
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_i,
  input  logic [DIV_W-1:0] new_div_i,
  output logic             enable_o
`ifdef SPART_DIV_READBACK_EN
  ,
  output logic [DIV_W-1:0] divisor_o
`endif
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             enable_q, enable_d;

  // Divisors of 0 and 1 both behave as 1 (tick every cycle)
  function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  // Next-state: commit wins over the counter, otherwise count down and wrap
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    if (commit_i) begin
      div_d = new_div_i;
      cnt_d = reload(new_div_i);
    end else if (cnt_q == '0) begin
      enable_d = 1'b1;
      cnt_d    = reload(div_q);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // State registers; reset restarts the count from the reset divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= RESET_DIV;
      cnt_q    <= reload(RESET_DIV);
      enable_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
    end
  end

  assign enable_o = enable_q;
`ifdef SPART_DIV_READBACK_EN
  assign divisor_o = div_q;
`endif

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus-side controller: decodes processor accesses, produces the
// receiver/transmitter strobes, drives the read path and sequences the
// two-byte divisor load into the baud generator.
// Optional build macro: SPART_DIV_READBACK_EN (divisor readback on 10/11).
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned      DIV_W     = 16,
  parameter logic [DIV_W-1:0] RESET_DIV = 16'd326
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] addr,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [7:0] rx_data,
  input  logic       rda,
  input  logic       tbr,
  output logic       rx_rd,
  output logic       tx_wr,
  output logic [7:0] tx_byte,
  output logic       enable,
  output logic       lo_pend
);

  addr_t      addr_e;
  logic       rd_acc, wr_acc;
  logic       rd_data, wr_data, wr_dbl, wr_dbh;
  div_state_t state_q, state_d;
  logic [7:0] shadow_lo_q, shadow_lo_d;
  logic       rx_rd_q, tx_wr_q;
  logic [7:0] tx_byte_q;
  logic [7:0] status;
  logic [7:0] rd_mux;
  logic [DIV_W-1:0] new_div;
`ifdef SPART_DIV_READBACK_EN
  logic [DIV_W-1:0] divisor;
`endif

  assign addr_e  = addr_t'(addr);
  assign rd_acc  = iocs & iorw;
  assign wr_acc  = iocs & ~iorw;
  assign rd_data = rd_acc && (addr_e == ADDR_DATA);
  assign wr_data = wr_acc && (addr_e == ADDR_DATA);
  assign wr_dbl  = wr_acc && (addr_e == ADDR_DBL);
  assign wr_dbh  = wr_acc && (addr_e == ADDR_DBH);
  assign new_div = DIV_W'({db_in, shadow_lo_q});

  // Divisor load FSM: stage the low byte, commit on the high-byte write
  always_comb begin
    state_d     = state_q;
    shadow_lo_d = shadow_lo_q;
    if (wr_dbl) begin
      shadow_lo_d = db_in;
      state_d     = LO_PEND;
    end else if (wr_dbh) begin
      state_d = RUN;
    end
  end

  // Registered strobes, transmit byte and divisor staging state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      shadow_lo_q <= RESET_DIV[7:0];
      rx_rd_q     <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      shadow_lo_q <= shadow_lo_d;
      rx_rd_q     <= rd_data & rda;
      tx_wr_q     <= wr_data & tbr;
      if (wr_data && tbr) begin
        tx_byte_q <= db_in;
      end
    end
  end

  // Status byte assembled from live flags plus the staging state
  always_comb begin
    status               = 8'h00;
    status[STAT_RDA]     = rda;
    status[STAT_TBR]     = tbr;
    status[STAT_LO_PEND] = (state_q == LO_PEND);
  end

  // Read path: combinational so data is valid in the access cycle
  always_comb begin
    rd_mux = 8'h00;
    case (addr_e)
      ADDR_DATA:   rd_mux = rx_data;
      ADDR_STATUS: rd_mux = status;
`ifdef SPART_DIV_READBACK_EN
      ADDR_DBL:    rd_mux = (state_q == LO_PEND) ? shadow_lo_q : divisor[7:0];
      ADDR_DBH:    rd_mux = divisor[15:8];
`else
      ADDR_DBL:    rd_mux = 8'h00;
      ADDR_DBH:    rd_mux = 8'h00;
`endif
      default:     rd_mux = 8'h00;
    endcase
  end

  assign db_oe  = rd_acc;
  assign db_out = rd_acc ? rd_mux : 8'h00;

  spart_baud_gen #(
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .commit_i  (wr_dbh),
    .new_div_i (new_div),
    .enable_o  (enable)
`ifdef SPART_DIV_READBACK_EN
    ,
    .divisor_o (divisor)
`endif
  );

  assign rx_rd   = rx_rd_q;
  assign tx_wr   = tx_wr_q;
  assign tx_byte = tx_byte_q;
  assign lo_pend = (state_q == LO_PEND);

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Self-checking bench for spart_bus_ctrl: a table of read-path vectors,
// hand-written divisor/strobe sequences and randomized traffic, all
// checked against a schedule-based reference model of the controller.
module tb_spart_bus_ctrl;

  localparam logic [15:0] RDIV = 16'd326;

  logic       clk = 1'b0;
  logic       rst, iocs, iorw, rda, tbr;
  logic [1:0] addr;
  logic [7:0] db_in, rx_data;
  logic [7:0] db_out, tx_byte;
  logic       db_oe, rx_rd, tx_wr, enable, lo_pend;

  always #5 clk = ~clk;

  spart_bus_ctrl #(.DIV_W(16), .RESET_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .addr(addr),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .rx_data(rx_data),
    .rda(rda), .tbr(tbr), .rx_rd(rx_rd), .tx_wr(tx_wr), .tx_byte(tx_byte),
    .enable(enable), .lo_pend(lo_pend)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ticks are scheduled as absolute cycle numbers
  logic [15:0] m_div;
  logic [7:0]  m_shadow, m_tx_byte;
  logic        m_pend, m_en, m_rx_rd, m_tx_wr;
  int          m_cycle, m_next;

  function automatic int eff(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (model cycle %0d)", name, act, exp, m_cycle);
    end
  endtask

  function automatic logic [7:0] m_read();
    logic [7:0] r;
    r = 8'h00;
    if (iocs && iorw) begin
      case (addr)
        2'd0: r = rx_data;
        2'd1: r = {5'b0, m_pend, tbr, rda};
`ifdef SPART_DIV_READBACK_EN
        2'd2: r = m_pend ? m_shadow : m_div[7:0];
        2'd3: r = m_div[15:8];
`endif
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    logic commit;
    if (rst) begin
      m_div = RDIV; m_shadow = RDIV[7:0]; m_tx_byte = 8'h00; m_pend = 1'b0;
      m_en = 1'b0; m_rx_rd = 1'b0; m_tx_wr = 1'b0;
      m_cycle = 0; m_next = eff(RDIV);
      return;
    end
    m_rx_rd = iocs && iorw && addr == 2'd0 && rda;
    m_tx_wr = iocs && !iorw && addr == 2'd0 && tbr;
    if (m_tx_wr) m_tx_byte = db_in;
    commit = 1'b0;
    if (iocs && !iorw && addr == 2'd2) begin
      m_shadow = db_in; m_pend = 1'b1;
    end
    if (iocs && !iorw && addr == 2'd3) begin
      m_div = {db_in, m_shadow}; m_pend = 1'b0; commit = 1'b1;
    end
    m_cycle++;
    if (commit) begin
      m_en = 1'b0; m_next = m_cycle + eff(m_div);
    end else if (m_cycle == m_next) begin
      m_en = 1'b1; m_next = m_cycle + eff(m_div);
    end else begin
      m_en = 1'b0;
    end
  endtask

  // One clock: check the combinational read path, clock, check registers
  task automatic cycle_t();
    #2;
    if (!rst) begin
      chk("db_oe", 32'(db_oe), 32'(iocs & iorw));
      chk("db_out", 32'(db_out), 32'(m_read()));
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("enable", 32'(enable), 32'(m_en));
    chk("rx_rd", 32'(rx_rd), 32'(m_rx_rd));
    chk("tx_wr", 32'(tx_wr), 32'(m_tx_wr));
    chk("tx_byte", 32'(tx_byte), 32'(m_tx_byte));
    chk("lo_pend", 32'(lo_pend), 32'(m_pend));
  endtask

  task automatic do_reset();
    rst = 1'b1; iocs = 1'b0;
    cycle_t(); cycle_t();
    rst = 1'b0;
  endtask

  task automatic bus(input logic rw, input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = rw; addr = a; db_in = d;
    #2;
    $display("[TB] bus %s addr=%0d din=%02h dout=%02h rda=%0b tbr=%0b",
             rw ? "rd" : "wr", a, d, db_out, rda, tbr);
    cycle_t();
    iocs = 1'b0;
  endtask

  // Count cycles until the DUT raises enable, bounded
  task automatic wait_tick(input string name, input int exp);
    int n;
    n = 0;
    iocs = 1'b0;
    do begin
      cycle_t();
      n++;
    end while (!enable && n < 2000);
    $display("[TB] tick %s after %0d cycles", name, n);
    chk(name, 32'(n), 32'(exp));
  endtask

  typedef struct {
    logic       cs, rw;
    logic [1:0] a;
    logic [7:0] din;
    logic       v_rda, v_tbr;
    logic [7:0] rxd;
    logic [7:0] exp_out;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] rb_lo, rb_hi;

  initial begin
`ifdef SPART_DIV_READBACK_EN
    rb_lo = 8'h46; rb_hi = 8'h01;
`else
    rb_lo = 8'h00; rb_hi = 8'h00;
`endif
    vecs[0] = '{1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h03, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h02, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 8'hFF, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 8'h11, rb_lo, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 8'h22, rb_hi, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 2'd0, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; addr = 2'd0; db_in = 8'h00;
    rx_data = 8'h00; rda = 1'b0; tbr = 1'b0;
    m_cycle = 0;

    // Reset release and idle ticking at the reset divisor
    do_reset();
    chk("reset_lo_pend", 32'(lo_pend), 32'd0);
    chk("reset_tx_byte", 32'(tx_byte), 32'd0);
    wait_tick("first_tick", 326);
    wait_tick("reset_period", 326);

    // Table-driven read-path vectors
    for (int i = 0; i < 9; i++) begin
      iocs = vecs[i].cs; iorw = vecs[i].rw; addr = vecs[i].a; db_in = vecs[i].din;
      rda = vecs[i].v_rda; tbr = vecs[i].v_tbr; rx_data = vecs[i].rxd;
      #2;
      $display("[TB] vec %0d cs=%0b rw=%0b a=%0d dout=%02h oe=%0b", i, iocs, iorw, addr, db_out, db_oe);
      chk("vec_db_out", 32'(db_out), 32'(vecs[i].exp_out));
      chk("vec_db_oe", 32'(db_oe), 32'(vecs[i].exp_oe));
      cycle_t();
    end
    iocs = 1'b0;

    // Receive read with and without data available
    rda = 1'b1; rx_data = 8'hA5;
    bus(1'b1, 2'd0, 8'h00);
    chk("rx_rd_pulse", 32'(rx_rd), 32'd1);
    cycle_t();
    chk("rx_rd_single", 32'(rx_rd), 32'd0);
    rda = 1'b0;
    bus(1'b1, 2'd0, 8'h00);
    chk("rx_rd_none", 32'(rx_rd), 32'd0);

    // Transmit write accepted, then dropped while busy
    tbr = 1'b1;
    bus(1'b0, 2'd0, 8'h3C);
    chk("tx_wr_pulse", 32'(tx_wr), 32'd1);
    chk("tx_byte_load", 32'(tx_byte), 32'h3C);
    tbr = 1'b0;
    bus(1'b0, 2'd0, 8'h77);
    chk("tx_wr_drop", 32'(tx_wr), 32'd0);
    chk("tx_byte_keep", 32'(tx_byte), 32'h3C);

    // Two-byte divisor load to 27, then re-commit using the held low byte
    bus(1'b0, 2'd2, 8'h1B);
    chk("lo_pend_set", 32'(lo_pend), 32'd1);
    bus(1'b1, 2'd1, 8'h00);
    bus(1'b0, 2'd3, 8'h00);
    chk("lo_pend_clr", 32'(lo_pend), 32'd0);
    wait_tick("div27_first", 27);
    wait_tick("div27_period", 27);
    bus(1'b0, 2'd3, 8'h00);
    wait_tick("div27_recommit", 27);

    // Divisor 0 ticks every cycle; then 4
    bus(1'b0, 2'd2, 8'h00);
    bus(1'b0, 2'd3, 8'h00);
    wait_tick("div0_first", 1);
    wait_tick("div0_period", 1);
    bus(1'b0, 2'd2, 8'h04);
    bus(1'b0, 2'd3, 8'h00);
    wait_tick("div4_first", 4);
    wait_tick("div4_period", 4);

    // Reset right after a staged low byte discards it
    bus(1'b0, 2'd2, 8'h55);
    rst = 1'b1;
    cycle_t();
    rst = 1'b0;
    chk("rst_lo_pend", 32'(lo_pend), 32'd0);
    wait_tick("rst_restart", 326);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      iocs    = $urandom_range(0, 1) == 1;
      iorw    = $urandom_range(0, 1) == 1;
      addr    = 2'($urandom_range(0, 3));
      rda     = $urandom_range(0, 1) == 1;
      tbr     = $urandom_range(0, 1) == 1;
      rx_data = 8'($urandom);
      if (addr == 2'd3)      db_in = 8'($urandom_range(0, 1));
      else if (addr == 2'd2) db_in = 8'($urandom_range(0, 7));
      else                   db_in = 8'($urandom);
      if (iocs) begin
        #2;
        $display("[TB] rnd %0d %s addr=%0d din=%02h dout=%02h rst=%0b",
                 i, iorw ? "rd" : "wr", addr, db_in, db_out, rst);
      end
      cycle_t();
    end
    rst = 1'b0; iocs = 1'b0;
    cycle_t();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
